mips_multicycle_ctrl: RTL and testbench

Main control FSM for the multi-cycle MIPS datapath. It decodes the instruction opcode and sequences one instruction over 3–5 cycles. It drives the PC, instruction register, memory, register-file and ALU operand muxes. It selects when the branch offset path (sign-extended immediate shifted left by 2) and the jump-target path (instr[25:0] shifted left by 2) feed the ALU and PC. Memory accesses stall on a ready handshake.

---
 rtl/mips_multicycle_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences FETCH/DECODE and
// the per-opcode execute paths, stalling memory states on mem_ready.
//
// state  | meaning
// -------+----------------------------------------------------------
// FETCH  | read instruction at PC, PC+4 -> PC when memory completes
// DECODE | read registers, precompute branch target into ALUOut
// MEMADR | compute lw/sw effective address
// MEMRD  | load data read, wait for mem_ready
// MEMWB  | write MDR to rt
// MEMWR  | store data write, wait for mem_ready
// EXEC   | R-type ALU operation
// ALUWB  | write ALUOut to rd
// BRANCH | beq compare, conditional PC load from ALUOut
// JUMP   | PC <= jump target
// ADDIEX | addi: reg A + sign-extended immediate
// ADDIWB | write ALUOut to rt

module mips_multicycle_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       illegal_op,
   output logic [3:0] state
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

   // Moore decode; FETCH's pc_write/ir_write are handled separately since they
   // depend on mem_ready in the same cycle.
   function automatic ctrl_t decode_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = 2'b01;
         end
         S_DECODE: c.alu_src_b = 2'b11;
         S_MEMADR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            c.mem_read = 1'b1;
            c.i_or_d   = 1'b1;
         end
         S_MEMWB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            c.mem_write = 1'b1;
            c.i_or_d    = 1'b1;
         end
         S_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 2'b10;
         end
         S_ALUWB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_op        = 2'b01;
            c.pc_write_cond = 1'b1;
            c.pc_source     = 2'b01;
         end
         S_JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = 2'b10;
         end
         S_ADDIEX: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         S_ADDIWB: c.reg_write = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

   state_t state_q, state_d;
   ctrl_t  ctrl_q, ctrl_d;
   logic   illegal_op_q, illegal_op_d;
   logic   op_legal;
   logic   fetch_done;

   always_comb begin
      op_legal = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                 (opcode == OP_BEQ)   || (opcode == OP_J)  || (opcode == OP_ADDI);
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDIEX;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (opcode == OP_LW)      state_d = S_MEMRD;
            else if (opcode == OP_SW) state_d = S_MEMWR;
            else                      state_d = S_FETCH;
         end
         S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   state_d = S_ALUWB;
         S_ALUWB:  state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         S_ADDIEX: state_d = S_ADDIWB;
         S_ADDIWB: state_d = S_FETCH;
         default:  state_d = S_FETCH;
      endcase
      ctrl_d       = decode_ctrl(state_d);
      illegal_op_d = (state_q == S_DECODE) && !op_legal;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_FETCH;
         ctrl_q       <= decode_ctrl(S_FETCH);
         illegal_op_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ctrl_q       <= ctrl_d;
         illegal_op_q <= illegal_op_d;
      end
   end

   // Gated by rst_n so an instruction load can never fire while held in reset.
   always_comb begin
      fetch_done = rst_n && (state_q == S_FETCH) && mem_ready;
   end

   assign pc_write      = ctrl_q.pc_write | fetch_done;
   assign ir_write      = fetch_done;
   assign pc_write_cond = ctrl_q.pc_write_cond;
   assign i_or_d        = ctrl_q.i_or_d;
   assign mem_read      = ctrl_q.mem_read;
   assign mem_write     = ctrl_q.mem_write;
   assign mem_to_reg    = ctrl_q.mem_to_reg;
   assign reg_dst       = ctrl_q.reg_dst;
   assign reg_write     = ctrl_q.reg_write;
   assign alu_src_a     = ctrl_q.alu_src_a;
   assign alu_src_b     = ctrl_q.alu_src_b;
   assign alu_op        = ctrl_q.alu_op;
   assign pc_source     = ctrl_q.pc_source;
   assign illegal_op    = illegal_op_q;
   assign state         = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed instruction runs plus random opcode and
// mem_ready traffic, checked each cycle against a per-instruction path model.

module tb_mips_multicycle_ctrl;

   localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5;
   localparam int EXEC = 6, ALUWB = 7, BRANCH = 8, JUMP = 9, ADDIEX = 10, ADDIWB = 11;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = 6'h00;
   logic       mem_ready = 1'b1;
   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic [3:0] state;

   mips_multicycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
   );

   always #5 clk = ~clk;

   logic [16:0] obs;
   assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                 reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: remaining states of the current instruction.
   int         path[$];
   logic [5:0] cur_op;
   bit         exp_ill;
   bit         instr_done;

   function automatic bit is_legal(input logic [5:0] op);
      return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h02 || op == 6'h08;
   endfunction

   function automatic void load_path(input logic [5:0] op);
      path = '{FETCH, DECODE};
      case (op)
         6'h23:   begin path.push_back(MEMADR); path.push_back(MEMRD); path.push_back(MEMWB); end
         6'h2B:   begin path.push_back(MEMADR); path.push_back(MEMWR); end
         6'h00:   begin path.push_back(EXEC); path.push_back(ALUWB); end
         6'h04:   path.push_back(BRANCH);
         6'h02:   path.push_back(JUMP);
         6'h08:   begin path.push_back(ADDIEX); path.push_back(ADDIWB); end
         default: ;
      endcase
   endfunction

   function automatic void new_instr();
      logic [5:0] ops [7];
      ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h00};
      ops[6] = 6'($urandom_range(0, 63));
      cur_op = ops[$urandom_range(0, 6)];
      load_path(cur_op);
   endfunction

   function automatic logic [16:0] exp_out(input int st, input bit mr, input bit ill);
      logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rdst = 0, rw = 0, asa = 0;
      logic [1:0] asb = 0, aop = 0, psrc = 0;
      case (st)
         FETCH:  begin mrd = 1; asb = 2'b01; pcw = mr; irw = mr; end
         DECODE: asb = 2'b11;
         MEMADR: begin asa = 1; asb = 2'b10; end
         MEMRD:  begin mrd = 1; iord = 1; end
         MEMWB:  begin rw = 1; m2r = 1; end
         MEMWR:  begin mwr = 1; iord = 1; end
         EXEC:   begin asa = 1; aop = 2'b10; end
         ALUWB:  begin rw = 1; rdst = 1; end
         BRANCH: begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
         JUMP:   begin pcw = 1; psrc = 2'b10; end
         ADDIEX: begin asa = 1; asb = 2'b10; end
         ADDIWB: rw = 1;
         default: ;
      endcase
      return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, ill};
   endfunction

   // Called at a negedge: drive, check, advance the model, wait for next negedge.
   task automatic step(input bit mr);
      int st;
      mem_ready = mr;
      opcode    = cur_op;
      #1;
      st = path[0];
      chk("state", 32'(state), 32'(st));
      chk("outputs", 32'(obs), 32'(exp_out(st, mr, exp_ill)));
      exp_ill    = (st == DECODE) && !is_legal(cur_op);
      instr_done = 1'b0;
      if (!((st == FETCH || st == MEMRD || st == MEMWR) && !mr)) begin
         void'(path.pop_front());
         if (path.size() == 0) begin
            new_instr();
            instr_done = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   task automatic run_instr(input logic [5:0] op, input int stall_st, input int stalls,
                            input int exp_cycles);
      int n = 0;
      int cycles = 0;
      bit mr;
      cur_op = op;
      load_path(op);
      do begin
         mr = !(path[0] == stall_st && n < stalls);
         if (!mr) n++;
         step(mr);
         cycles++;
      end while (!instr_done && cycles < 50);
      chk($sformatf("cycles op=%0h", op), 32'(cycles), 32'(exp_cycles));
   endtask

   initial begin
      int guard;
      @(negedge clk);
      #1;
      chk("reset state", 32'(state), 32'(FETCH));
      chk("reset outputs", 32'(obs), 32'(exp_out(FETCH, 1'b0, 1'b0)));
      @(negedge clk);
      rst_n   = 1'b1;
      exp_ill = 1'b0;
      new_instr();

      run_instr(6'h23, -1,    0, 5);
      run_instr(6'h2B, MEMWR, 3, 7);
      run_instr(6'h04, -1,    0, 3);
      run_instr(6'h02, -1,    0, 3);
      run_instr(6'h00, -1,    0, 4);
      run_instr(6'h08, -1,    0, 4);
      run_instr(6'h3F, -1,    0, 2);
      run_instr(6'h23, MEMRD, 2, 7);
      run_instr(6'h04, FETCH, 2, 5);
      run_instr(6'h00, -1,    0, 4);

      for (int i = 0; i < 600; i++) step($urandom_range(0, 3) != 0);

      // Abort a load in MEMRD with an asynchronous reset between edges.
      while (!instr_done) step(1'b1);
      cur_op = 6'h23;
      load_path(cur_op);
      guard = 0;
      while (path[0] != MEMRD && guard < 20) begin
         step(1'b1);
         guard++;
      end
      chk("reach MEMRD", 32'(guard < 20), 32'd1);
      mem_ready = 1'b0;
      #1;
      chk("memrd state", 32'(state), 32'(MEMRD));
      #2;
      rst_n     = 1'b0;
      mem_ready = 1'b1;
      #1;
      chk("async reset state", 32'(state), 32'(FETCH));
      chk("async reset outputs", 32'(obs), 32'(exp_out(FETCH, 1'b0, 1'b0)));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("reset hold reg_write", 32'(reg_write), 32'd0);
         chk("reset hold strobes", 32'({pc_write, ir_write}), 32'd0);
      end
      @(negedge clk);
      rst_n   = 1'b1;
      exp_ill = 1'b0;
      new_instr();
      for (int i = 0; i < 100; i++) step($urandom_range(0, 3) != 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
